// File: rtl/prng_word_buffer.sv
// Prefetch FIFO between the xoshiro generator and the bus: keeps DEPTH words
// buffered and serves byte/halfword/word reads from the oldest entry.
module prng_word_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       prng_next,
  input  logic [31:0]                prng_rnd,
  input  logic                       prng_busy,
  input  logic                       flush,
  input  logic                       rd_req,
  input  logic [1:0]                 rd_width,
  output logic                       rd_ack,
  output logic [31:0]                rd_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW+1:0] DEPTH_W  = (AW+2)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_ZERO = '0;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          pending_reg;
  logic          rd_ack_reg;
  logic [31:0]   rd_data_reg;

  logic [AW+1:0] committed;
  logic          push;
  logic          pop;
  logic [31:0]   head_word;
  logic [31:0]   head_masked;
  logic [AW:0]   level_next;
  logic [AW-1:0] wr_ptr_next;
  logic [AW-1:0] rd_ptr_next;

  // Credit counts words already stored plus the one possibly in flight;
  // a pop in this cycle does not free a slot until the next one.
  assign committed = {1'b0, level_reg} + {{(AW+1){1'b0}}, pending_reg};
  assign prng_next = rst_n & ~prng_busy & ~flush & (committed < DEPTH_W);

  assign push = pending_reg & ~flush;
  assign pop  = rd_req & ~rd_ack_reg & (level_reg != LVL_ZERO) & ~flush;

  assign head_word = mem[rd_ptr_reg];

  always_comb begin
    head_masked = head_word;
    case (rd_width)
      WIDTH_BYTE: head_masked = {24'h0, head_word[7:0]};
      WIDTH_HALF: head_masked = {16'h0, head_word[15:0]};
      default:    head_masked = head_word;
    endcase
  end

  always_comb begin
    level_next  = level_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_ONE;
      2'b01:   level_next = level_reg - LVL_ONE;
      default: level_next = level_reg;
    endcase
  end

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= prng_rnd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      pending_reg <= 1'b0;
      rd_ack_reg  <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      pending_reg <= prng_next;
      rd_ack_reg  <= pop;
      if (pop) begin
        rd_data_reg <= head_masked;
      end
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        wr_ptr_reg <= wr_ptr_next;
        rd_ptr_reg <= rd_ptr_next;
        level_reg  <= level_next;
      end
    end
  end

  assign rd_ack  = rd_ack_reg;
  assign rd_data = rd_data_reg;
  assign level   = level_reg;

endmodule

// File: tb/tb_prng_word_buffer.sv
// Randomized bench for prng_word_buffer: stub xoshiro generator, queue-based
// reference model, and a scoreboard monitor that checks every rd_ack word.
module tb_prng_word_buffer;

  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [31:0] STUB_BASE = 32'h1234_5670;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prng_next;
  logic [31:0]   prng_rnd;
  logic          prng_busy;
  logic          flush;
  logic          rd_req;
  logic [1:0]    rd_width;
  logic          rd_ack;
  logic [31:0]   rd_data;
  logic [LW-1:0] level;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  bit          m_pend = 0;
  bit          m_ack = 0;
  logic [31:0] m_inflight = '0;
  int unsigned m_k = 0;
  int unsigned stub_k = 0;

  prng_word_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prng_next (prng_next),
    .prng_rnd  (prng_rnd),
    .prng_busy (prng_busy),
    .flush     (flush),
    .rd_req    (rd_req),
    .rd_width  (rd_width),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Stub generator: word k appears the cycle after the k-th next.
  always @(posedge clk) begin
    if (prng_next === 1'b1) begin
      prng_rnd <= STUB_BASE + stub_k;
      stub_k   <= stub_k + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] width_view(input logic [31:0] w, input logic [1:0] sel);
    if (sel == 2'd0) return w % 32'd256;
    if (sel == 2'd1) return w % 32'd65536;
    return w;
  endfunction

  // Scoreboard monitor: each ack must match the oldest expected read.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_ack: got data %h expected no ack at %0t", rd_data, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e);
        $display("[TB] read ack data=%h expected=%h", rd_data, e);
      end
    end
  end

  // One clock of stimulus; the model then advances to the post-edge state.
  task automatic step(input bit f, input bit b, input bit rq, input logic [1:0] w);
    bit exp_next;
    bit accept;
    @(negedge clk);
    flush = f; prng_busy = b; rd_req = rq; rd_width = w;
    #1;
    exp_next = !b && !f && ((model_q.size() + int'(m_pend)) < DEPTH);
    chk("prng_next", {31'h0, prng_next}, {31'h0, exp_next});
    chk("level", 32'(level), 32'(model_q.size()));
    chk("rd_ack", {31'h0, rd_ack}, {31'h0, m_ack});
    accept = rq && !m_ack && model_q.size() > 0 && !f;
    if (accept) exp_q.push_back(width_view(model_q.pop_front(), w));
    if (f) model_q.delete();
    else if (m_pend) model_q.push_back(m_inflight);
    m_ack  = accept;
    m_pend = exp_next;
    if (exp_next) begin
      m_inflight = STUB_BASE + m_k;
      m_k++;
    end
  endtask

  task automatic reset_core();
    @(negedge clk);
    prng_busy = 1'b1; rd_req = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_ack", {31'h0, rd_ack}, 32'h0);
    chk("rst_data", rd_data, 32'h0);
    chk("rst_next", {31'h0, prng_next}, 32'h0);
    model_q.delete();
    m_pend = 0;
    m_ack = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit rq_cur;
    logic [1:0] w_cur;
    bit f_r;
    bit b_r;
    rst_n = 1'b0; prng_busy = 1'b1; flush = 1'b0; rd_req = 1'b0; rd_width = 2'd0;
    prng_rnd = '0;
    reset_core();

    // Fill after reset, then reads of each width from a full buffer.
    for (int i = 0; i < 7; i++) step(0, 0, 0, 2'd2);
    chk("fill_level", 32'(level), 32'(DEPTH));
    step(0, 0, 1, 2'd2); step(0, 0, 0, 2'd2); step(0, 0, 0, 2'd2);
    step(0, 0, 1, 2'd0); step(0, 0, 1, 2'd0); step(0, 0, 0, 2'd0);
    step(0, 0, 1, 2'd1); step(0, 0, 0, 2'd1); step(0, 0, 0, 2'd1);

    // Flush to empty, read while busy, then release busy.
    step(1, 1, 0, 2'd2);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 2'd2);
    for (int i = 0; i < 5; i++) step(0, 0, (i < 3) ? 1'b1 : 1'b0, 2'd2);

    // Flush with a word in flight and a partly filled buffer.
    step(1, 0, 0, 2'd2);
    step(0, 0, 0, 2'd2); step(0, 0, 0, 2'd2); step(0, 0, 0, 2'd2);
    step(1, 0, 0, 2'd2);
    step(0, 0, 1, 2'd2); step(0, 0, 1, 2'd2); step(0, 0, 1, 2'd2);
    step(0, 0, 0, 2'd2);

    // Continuous reads on alternate cycles exercise pointer wrap.
    for (int i = 0; i < 24; i++) step(0, 0, i[0] == 1'b0, 2'd2);

    // Randomized traffic with occasional mid-run reset.
    rq_cur = 0; w_cur = 2'd2;
    for (int i = 0; i < 800; i++) begin
      if (rq_cur) begin
        if (m_ack && $urandom_range(3) != 0) rq_cur = 0;
      end else if ($urandom_range(2) == 0) begin
        rq_cur = 1;
        w_cur = 2'($urandom_range(3));
      end
      f_r = ($urandom_range(24) == 0);
      b_r = ($urandom_range(7) == 0);
      step(f_r, b_r, rq_cur, w_cur);
      if (i % 250 == 249) begin
        step(0, 0, 0, 2'd2); step(0, 0, 0, 2'd2);
        rq_cur = 0;
        reset_core();
      end
    end

    for (int i = 0; i < 5; i++) step(0, 0, 0, 2'd2);
    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prng_word_buffer.md
PRNG_WORD_BUFFER -- requirements
Module: prng_word_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in 32-bit words (power of two, 2..16).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 prng_next  output  1  combinational request to generator; one word per cycle high.
REQ-005 prng_rnd  input  32  generator output word, valid the cycle after prng_next was high.
REQ-006 prng_busy  input  1  generator seeding/being written; any next issued now would be ignored.
REQ-007 flush  input  1  discard all buffered and in-flight words.
REQ-008 rd_req  input  1  read request, held high until rd_ack.
REQ-009 rd_width  input  2  00 byte, 01 halfword, 10/11 word.
REQ-010 rd_ack  output  1  registered one-cycle pulse; rd_data valid in that cycle.
REQ-011 rd_data  output  32  zero-extended random value.
REQ-012 level  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Block SHALL be the consumer of the 32-bit xoshiro generator: it pre-fetches words into a FIFO and serves bus reads from it.
REQ-014 pending register SHALL equal prng_next of the previous cycle (one in-flight word max per issued cycle).
REQ-015 prng_next SHALL = !prng_busy && !flush && (level + pending) < DEPTH; pops in the same cycle earn no credit.
REQ-016 When pending=1 and flush=0, prng_rnd SHALL be pushed at that rising edge; back-to-back next/capture every cycle SHALL be supported.
REQ-017 A read SHALL be accepted in a cycle where rd_req=1, rd_ack=0, level>0, flush=0; it pops the head word at that edge.
REQ-018 Accepted read SHALL register rd_ack=1 and rd_data = head masked per rd_width (byte [7:0], half [15:0], word [31:0], upper bits 0) for exactly the next cycle.
REQ-019 rd_req high while rd_ack=1 SHALL NOT be accepted (no double pop); requester drops rd_req in the ack cycle.
REQ-020 rd_req with level=0 SHALL wait (no ack) until a word is pushed; no timeout.
REQ-021 Simultaneous push and pop SHALL leave level unchanged, order preserved (FIFO, oldest first).
REQ-022 Push SHALL never occur when full (guaranteed by REQ-015); pop SHALL never occur when empty.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH.
REQ-024 flush SHALL take priority: at the edge, level:=0, pointers:=0, pending:=0, the in-flight capture is dropped, no pop; rd_ack/rd_data unaffected if already registered.
REQ-025 prng_busy high SHALL only suppress prng_next; buffered words and an in-flight capture are retained (software flushes after reseed).
REQ-026 Empty-FIFO read latency: next in cycle N, push at end of N+1, accept at end of N+2, rd_ack in N+3.

Reset
REQ-027 On rst_n low, asynchronously: level=0, pointers=0, pending=0, rd_ack=0, rd_data=0; FIFO storage contents need not be cleared.
REQ-028 prng_next SHALL be low while rst_n is low; after release it follows REQ-015 (generator's own post-reset seeding holds prng_busy high).
REQ-029 Reset mid-operation SHALL drop the in-flight word and any unacknowledged read.

Verification (stub generator: rnd after k-th next = 0x1234_5670 + k, k from 0)
REQ-030 Reset release, busy=0, no reads -> prng_next high 4 consecutive cycles then low; level reaches 4 and stays; no further next.
REQ-031 Full FIFO, rd_req width=10 -> rd_ack next cycle, rd_data=0x1234_5670; one refill next issued; level returns to 4.
REQ-032 Successive reads width=00 then 01 -> rd_data 0x0000_0071 then 0x0000_5672; rd_req held through ack gives exactly one ack per request.
REQ-033 Empty FIFO, busy=1, rd_req=1 -> no next, no ack; busy drops in cycle N -> prng_next in N, rd_ack in N+3 with next stub word.
REQ-034 flush asserted while pending=1 and level=2 -> level 0 next cycle, in-flight word never appears; following read returns a later word.
REQ-035 Full FIFO, continuous reads each other cycle -> push and pop coincide, level constant at DEPTH-1/DEPTH, words returned strictly in stub order, pointers wrap correctly past DEPTH.
